// File: rtl/binary_attention_core.sv
// rtl/binary_attention_core.sv - binary XNOR-popcount self-attention over one buffered Q/K/V sequence
module binary_attention_core #(
   parameter int D_W     = 16,
   parameter int SEQ_LEN = 30,
   parameter int THRESH  = 8,
   parameter int ACC_W   = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [D_W-1:0] query_in,
   input  logic [D_W-1:0] key_in,
   input  logic [D_W-1:0] value_in,
   input  logic           qkv_valid,
   output logic           in_ready,
   output logic [D_W-1:0] attn_out,
   output logic           attn_valid,
   output logic           busy,
   output logic           done,
   output logic           drop_err
);

   localparam int PTR_W   = $clog2(SEQ_LEN);
   localparam int SCORE_W = $clog2(D_W + 1);

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SEQ_LEN - 1);

   logic [1:0]       state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] qi;
   logic [PTR_W-1:0] kj;

   logic [D_W-1:0] q_mem [SEQ_LEN];
   logic [D_W-1:0] k_mem [SEQ_LEN];
   logic [D_W-1:0] v_mem [SEQ_LEN];

   logic signed [ACC_W-1:0] acc      [D_W];
   logic signed [ACC_W-1:0] acc_next [D_W];

   logic [D_W-1:0]     match;
   logic [D_W-1:0]     v_row;
   logic [D_W-1:0]     row_bits;
   logic [SCORE_W-1:0] score;
   logic               attend;
   logic               load_fire;

   assign in_ready  = (state == ST_LOAD);
   assign busy      = (state == ST_COMPUTE);
   assign load_fire = in_ready && qkv_valid;

   // Token buffers are not reset; a new LOAD always overwrites all entries before use.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         q_mem[wr_ptr] <= query_in;
         k_mem[wr_ptr] <= key_in;
         v_mem[wr_ptr] <= value_in;
      end
   end

   always_comb begin
      match  = ~(q_mem[qi] ^ k_mem[kj]);
      v_row  = v_mem[kj];
      score  = '0;
      for (int i = 0; i < D_W; i++) begin
         score = score + SCORE_W'(match[i]);
      end
      attend = (score >= SCORE_W'(THRESH));
      for (int b = 0; b < D_W; b++) begin
         if (!attend) begin
            acc_next[b] = acc[b];
         end else if (v_row[b]) begin
            acc_next[b] = acc[b] + ACC_W'(1);
         end else begin
            acc_next[b] = acc[b] - ACC_W'(1);
         end
         // Non-negative vote (ties and empty rows included) yields a 1.
         row_bits[b] = ~acc_next[b][ACC_W-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_LOAD;
         wr_ptr     <= '0;
         qi         <= '0;
         kj         <= '0;
         attn_out   <= '0;
         attn_valid <= 1'b0;
         done       <= 1'b0;
         drop_err   <= 1'b0;
         for (int b = 0; b < D_W; b++) begin
            acc[b] <= '0;
         end
      end else begin
         attn_valid <= 1'b0;
         done       <= 1'b0;
         if (qkv_valid && !in_ready) begin
            drop_err <= 1'b1;
         end
         case (state)
            ST_LOAD: begin
               if (qkv_valid) begin
                  if (wr_ptr == LAST_IDX) begin
                     wr_ptr <= '0;
                     qi     <= '0;
                     kj     <= '0;
                     state  <= ST_COMPUTE;
                     for (int b = 0; b < D_W; b++) begin
                        acc[b] <= '0;
                     end
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            ST_COMPUTE: begin
               if (kj == LAST_IDX) begin
                  attn_out   <= row_bits;
                  attn_valid <= 1'b1;
                  kj         <= '0;
                  for (int b = 0; b < D_W; b++) begin
                     acc[b] <= '0;
                  end
                  if (qi == LAST_IDX) begin
                     qi    <= '0;
                     state <= ST_DONE;
                  end else begin
                     qi <= qi + 1'b1;
                  end
               end else begin
                  kj <= kj + 1'b1;
                  for (int b = 0; b < D_W; b++) begin
                     acc[b] <= acc_next[b];
                  end
               end
            end
            ST_DONE: begin
               // done is registered so it lands one cycle after the final row pulse.
               done   <= 1'b1;
               wr_ptr <= '0;
               state  <= ST_LOAD;
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binary_attention_core.sv
// tb/tb_binary_attention_core.sv - scoreboard bench for binary_attention_core
module tb_binary_attention_core;

   logic        clk;
   logic        rst;
   logic [15:0] query_in;
   logic [15:0] key_in;
   logic [15:0] value_in;
   logic        qkv_valid;
   logic        in_ready;
   logic [15:0] attn_out;
   logic        attn_valid;
   logic        busy;
   logic        done;
   logic        drop_err;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] sb [$];

   binary_attention_core dut (
      .clk        (clk),
      .rst        (rst),
      .query_in   (query_in),
      .key_in     (key_in),
      .value_in   (value_in),
      .qkv_valid  (qkv_valid),
      .in_ready   (in_ready),
      .attn_out   (attn_out),
      .attn_valid (attn_valid),
      .busy       (busy),
      .done       (done),
      .drop_err   (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && attn_valid) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL row_unexpected: got %h expected no row", attn_out);
         end else begin
            logic [15:0] e;
            e = sb.pop_front();
            if (attn_out !== e) begin
               fails++;
               $display("FAIL row_value: got %h expected %h", attn_out, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic load_seq(input logic [15:0] q_e, input logic [15:0] k_e, input logic [15:0] v_e,
                           input logic [15:0] q_o, input logic [15:0] k_o, input logic [15:0] v_o,
                           input logic [15:0] exp);
      int bad;
      bad = 0;
      for (int i = 0; i < 30; i++) sb.push_back(exp);
      for (int i = 0; i < 30; i++) begin
         query_in  = (i % 2 == 0) ? q_e : q_o;
         key_in    = (i % 2 == 0) ? k_e : k_o;
         value_in  = (i % 2 == 0) ? v_e : v_o;
         qkv_valid = 1'b1;
         if (in_ready !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      qkv_valid = 1'b0;
      chk("in_ready_load", bad, 0);
   endtask

   task automatic run_seq(input string nm, input int inject_at, input int abort_rows);
      int n, busy_cnt, first, last, rows;
      bit got_done;
      n = 0; busy_cnt = 0; first = -1; last = -1; rows = 0; got_done = 0;
      chk({nm, "_busy_rise"}, busy, 1);
      while (n < 1200) begin
         if (busy) busy_cnt++;
         if (attn_valid) begin
            rows++;
            if (first < 0) first = n;
            last = n;
         end
         if (done) begin
            got_done = 1;
            break;
         end
         if (abort_rows > 0 && rows == abort_rows) begin
            #2 rst = 1'b1;
            #1;
            chk({nm, "_rst_in_ready"}, in_ready, 1);
            chk({nm, "_rst_quiet"}, {attn_valid, busy, done, drop_err}, 0);
            chk({nm, "_rst_attn_out"}, attn_out, 0);
            sb.delete();
            return;
         end
         if (n == inject_at) begin
            query_in  = 16'h0000;
            key_in    = 16'h0000;
            value_in  = 16'hFFFF;
            qkv_valid = 1'b1;
            chk({nm, "_in_ready_busy"}, in_ready, 0);
         end else begin
            qkv_valid = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      qkv_valid = 1'b0;
      chk({nm, "_done_seen"}, got_done, 1);
      chk({nm, "_compute_cycles"}, busy_cnt, 900);
      chk({nm, "_first_latency"}, first, 30);
      chk({nm, "_done_after_last"}, n - last, 1);
      chk({nm, "_rows"}, rows, 30);
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, done, 0);
      chk({nm, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      int stray;
      rst = 1'b1; qkv_valid = 1'b0;
      query_in = '0; key_in = '0; value_in = '0;
      #12;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_attn_valid", attn_valid, 0);
      chk("reset_attn_out", attn_out, 0);
      chk("reset_drop_err", drop_err, 0);
      @(posedge clk); #1 rst = 1'b0;

      load_seq(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run_seq("all_ones", -1, 0);
      load_seq(16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
      run_seq("neg_vote", -1, 0);
      load_seq(16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0000, 16'h1234, 16'h00FF);
      run_seq("even_keys", -1, 0);
      load_seq(16'h0000, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0000, 16'h1234, 16'h1234);
      run_seq("odd_keys", -1, 0);
      load_seq(16'hFFFF, 16'h00FF, 16'h0000, 16'hFFFF, 16'h007F, 16'hFFFF, 16'h0000);
      run_seq("thresh_edge", -1, 0);
      load_seq(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
      run_seq("empty_rows", -1, 0);

      chk("drop_err_before", drop_err, 0);
      load_seq(16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0000, 16'h1234, 16'h00FF);
      run_seq("dropped", 5, 0);
      chk("drop_err_set", drop_err, 1);
      load_seq(16'h0000, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0000, 16'h1234, 16'h1234);
      run_seq("after_drop", -1, 0);
      chk("drop_err_sticky", drop_err, 1);

      load_seq(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run_seq("abort", -1, 5);
      @(posedge clk); #1 rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 1000; i++) begin
         if (attn_valid || done || busy) stray++;
         @(posedge clk); #1;
      end
      chk("abort_no_activity", stray, 0);
      chk("abort_in_ready", in_ready, 1);
      load_seq(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run_seq("post_reset", -1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
